// File: rtl/debounce_multi.sv
// debounce_multi: N-channel button/switch debouncer with press, release
// and long-press/auto-repeat pulses, all timed by one shared prescaler.
//
// Parameters:
//   N_CH         number of independent channels
//   TICK_DIV     clock cycles per time-base tick (>= 2)
//   DB_TICKS     ticks of steady disagreement needed to accept a level
//   HOLD_TICKS   ticks held high before the first o_hold pulse
//   REPEAT_EN    1: o_hold repeats while held, 0: one pulse per press
//   REPEAT_TICKS ticks between auto-repeat pulses
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_input      raw asynchronous inputs
//   o_debounce   debounced level per channel
//   o_rise       1-cycle pulse on debounced 0->1
//   o_fall       1-cycle pulse on debounced 1->0
//   o_hold       1-cycle long-press / auto-repeat pulse
module debounce_multi #(
  parameter int N_CH         = 5,
  parameter int TICK_DIV     = 100_000,
  parameter int DB_TICKS     = 20,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_TICKS = 100
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_input,
  output logic [N_CH-1:0] o_debounce,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_hold
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS
                                                    : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic          r_hold;
    logic          r_fired;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hcnt;
    state_t        r_st;
    logic          w_diff;
    logic          w_acc;
    logic          w_rise_ev;
    logic          w_fall_ev;

    assign w_diff    = r_s2 ^ r_db;
    assign w_acc     = w_diff & w_tick & (r_db_cnt == DB_LAST);
    assign w_rise_ev = w_acc & r_s2;
    assign w_fall_ev = w_acc & ~r_s2;

    // Synchroniser and debounce window; agreement clears the
    // count on any cycle, so short glitches restart the window.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_db     <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_s1   <= i_input[k];
        r_s2   <= r_s1;
        r_rise <= w_rise_ev;
        r_fall <= w_fall_ev;
        if (!w_diff) begin
          r_db_cnt <= '0;
        end else if (w_tick) begin
          if (r_db_cnt == DB_LAST) begin
            r_db     <= r_s2;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
          end
        end
      end
    end

    // Long-press FSM. A fall overrides everything, so a release
    // on the expiry tick never emits o_hold. r_fired freezes the
    // single-shot case in WAIT after its one pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_st    <= ST_IDLE;
        r_hcnt  <= '0;
        r_hold  <= 1'b0;
        r_fired <= 1'b0;
      end else begin
        r_hold <= 1'b0;
        if (w_fall_ev) begin
          r_st    <= ST_IDLE;
          r_hcnt  <= '0;
          r_fired <= 1'b0;
        end else begin
          unique case (r_st)
            ST_IDLE: begin
              if (w_rise_ev) begin
                r_st    <= ST_WAIT;
                r_hcnt  <= '0;
                r_fired <= 1'b0;
              end
            end
            ST_WAIT: begin
              if (w_tick && !r_fired) begin
                if (r_hcnt == HOLD_LAST) begin
                  r_hold <= 1'b1;
                  r_hcnt <= '0;
                  if (REPEAT_EN != 0) begin
                    r_st <= ST_REPEAT;
                  end else begin
                    r_fired <= 1'b1;
                  end
                end else begin
                  r_hcnt <= r_hcnt + HW'(1);
                end
              end
            end
            ST_REPEAT: begin
              if (w_tick) begin
                if (r_hcnt == REP_LAST) begin
                  r_hold <= 1'b1;
                  r_hcnt <= '0;
                end else begin
                  r_hcnt <= r_hcnt + HW'(1);
                end
              end
            end
            default: begin
              r_st <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign o_debounce[k] = r_db;
    assign o_rise[k]     = r_rise;
    assign o_fall[k]     = r_fall;
    assign o_hold[k]     = r_hold;
  end

endmodule
